multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing the 16-bit multi-cycle Datapath: one instruction at a time, FETCH -> DECODE -> EXEC -> MEM/WB.
//  Drives every control input of Datapath from the current state and the IR opcode. Sits beside Datapath in the CPU top.
//  Opcode encodings and state codes live in risc16_pkg and are shared with the bench.
// PARAMETERS
//  HALT_OP   4'hF  opcode that parks the FSM in HALT until reset
//  ST_W      4     width of state register / dbg_state port
// PORTS
//  clk         in   1   single clock; FSM advances on posedge
//  rst_n       in   1   asynchronous, active-low reset
//  opcode      in   4   IR_out[15:12] from Datapath
//  hold        in   1   1 = freeze FSM in current state; all write/strobe outputs forced 0
//  PCWrite, PCWriteCond, BNEq, MemRd, MemWr, IRd, IRWr, RegWrite  out 1 each  Datapath strobes
//  RegDst, MemToReg, SESF, JE, ALUSrcA  out 1 each  2:1 mux selects
//  R1Src, ALUSrcB, PCSrc  out 2 each  4:1 mux selects
//  ALUCtrl     out  3   ALU op (000 add,001 sub,010 sll,011 srl,100 sar,101 nand,110 or)
//  instr_done  out  1   1-cycle pulse in the last state of each instruction
//  halted      out  1   1 while in HALT
//  dbg_state   out  ST_W  current state code
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 while rst_n=0 and in IDLE; IDLE -> FETCH on first posedge after release.
//  Outputs are pure decode of (state, opcode). Unlisted signals are 0 in every state.
//  FETCH : IRd=IRWr=1, ALUSrcA=0, ALUSrcB=01 (+2), ALUCtrl=add, PCSrc=10, PCWrite=1 -> DECODE
//  DECODE: ALUSrcA=0, ALUSrcB=11, SESF=1 (ALUOut = PC+2 + sext(IR[7:0])<<1); R1Src per opcode.
//  Opcode map (R1Src held from DECODE to instruction end):
//   0x0-0x6 ALU-R: RA<=R[RB] op R[RC]. R1Src=01. EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUCtrl=opcode[2:0] -> WB_ALU
//   0x7 ADDI: RA<=R[RA]+sext(IR[7:0]). R1Src=10. EXEC_I: ALUSrcA=1, ALUSrcB=10, SESF=1, JE=0, add -> WB_ALU
//   0x8 ORI : RA<=R[RA]|zext(IR[7:0]). As ADDI with SESF=0, ALUCtrl=or -> WB_ALU
//   WB_ALU: RegDst=0, MemToReg=0, RegWrite=1, instr_done -> FETCH
//   0x9 LW R{11,RD}<=M[R{10,RP}+sext(imm8)]: R1Src=00. ADDR: ALUSrcA=1, ALUSrcB=10, SESF=1, add -> MEM_RD(MemRd=1) -> WB_MEM(RegDst=1, MemToReg=1, RegWrite=1, done)
//   0xA SW M[...]<=R{11,RD}: ADDR -> MEM_WR(MemWr=1, RegDst=1, done) -> FETCH
//   0xB BEQ / 0xC BNE on R[RA] vs R[RC]: R1Src=10. BR: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSrc=00, BNEq=(opcode==0xC), done -> FETCH
//   0xD J: JMP: ALUSrcA=0, ALUSrcB=10, JE=1, add, PCSrc=10, PCWrite=1, done -> FETCH (PC+2+sext(IR[11:0]))
//   0xE JR: JMP_R: RegDst=1, PCSrc=01, PCWrite=1, done -> FETCH (PC<=R{11,RD} via C)
//   HALT_OP: DECODE -> HALT; HALT self-loops, halted=1, no strobes; exit only via rst_n.
//  Cycles/instr incl. FETCH: ALU-R/ADDI/ORI 4, LW 5, SW 4, BEQ/BNE 3, J/JR 3.
//  hold=1: state frozen, PCWrite/PCWriteCond/MemRd/MemWr/IRd/IRWr/RegWrite/instr_done=0; mux selects keep their state decode.
//   Released hold resumes the same state and re-issues its strobes once.
//  rst_n falling mid-instruction: immediate IDLE, all outputs 0 same instant. Partial instruction abandoned (PC/regs untouched by FSM).
//  Unknown state code: next state IDLE, outputs 0.
// STRUCTURE
//  risc16_pkg: opcode localparams (OP_ADD..OP_JR, OP_HALT), ALU op codes, mux select codes (ASB_REG/ASB_TWO/ASB_IMM/ASB_SHL, PCS_*, R1S_*), state codes.
//  One sub-module: multicycle_ctrl_decode, combinational (state, opcode) -> control bundle. Top holds only the state register and next-state logic.
// TESTING
//  Reset then release: first cycle IDLE all-0; next cycle FETCH with PCWrite=IRWr=IRd=1, ALUSrcB=01, PCSrc=10.
//  opcode=0x1 (SUB): states FETCH,DECODE,EXEC_R,WB_ALU; ALUCtrl=001 in EXEC_R; RegWrite=1 only in WB_ALU; instr_done once.
//  opcode=0x9 (LW): 5 cycles; MemRd=1 exactly in MEM_RD; WB_MEM RegDst=1, MemToReg=1, RegWrite=1; R1Src=00 DECODE..WB_MEM.
//  opcode=0xC (BNE): BR state PCWriteCond=1, BNEq=1, ALUCtrl=001, PCSrc=00; 0xB gives BNEq=0.
//  hold=1 for 3 cycles during MEM_WR of SW: MemWr=0, dbg_state constant; after release MemWr=1 for one cycle, then FETCH.
//  opcode=0xF: halted=1 from cycle after DECODE, no strobes for 20 cycles; rst_n pulse low -> IDLE, then FETCH.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared encodings for the 16-bit multi-cycle CPU: opcodes, ALU ops, mux selects,
// FSM state codes and the controller's output bundle.
package risc16_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_SLL  = 4'h2;
   localparam logic [3:0] OP_SRL  = 4'h3;
   localparam logic [3:0] OP_SAR  = 4'h4;
   localparam logic [3:0] OP_NAND = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_ORI  = 4'h8;
   localparam logic [3:0] OP_LW   = 4'h9;
   localparam logic [3:0] OP_SW   = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_BNE  = 4'hC;
   localparam logic [3:0] OP_J    = 4'hD;
   localparam logic [3:0] OP_JR   = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_SLL  = 3'b010;
   localparam logic [2:0] ALU_SRL  = 3'b011;
   localparam logic [2:0] ALU_SAR  = 3'b100;
   localparam logic [2:0] ALU_NAND = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;

   localparam logic [1:0] ASB_REG = 2'b00;
   localparam logic [1:0] ASB_TWO = 2'b01;
   localparam logic [1:0] ASB_IMM = 2'b10;
   localparam logic [1:0] ASB_SHL = 2'b11;

   localparam logic [1:0] PCS_ALUOUT = 2'b00;
   localparam logic [1:0] PCS_REG    = 2'b01;
   localparam logic [1:0] PCS_ALU    = 2'b10;

   // R1 read-port source: R{10,RP}, RB or RA
   localparam logic [1:0] R1S_RP = 2'b00;
   localparam logic [1:0] R1S_RB = 2'b01;
   localparam logic [1:0] R1S_RA = 2'b10;

   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      StIdle   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StExecR  = 4'd3,
      StExecI  = 4'd4,
      StWbAlu  = 4'd5,
      StAddr   = 4'd6,
      StMemRd  = 4'd7,
      StWbMem  = 4'd8,
      StMemWr  = 4'd9,
      StBr     = 4'd10,
      StJmp    = 4'd11,
      StJmpR   = 4'd12,
      StHalt   = 4'd13
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       bneq;
      logic       mem_rd;
      logic       mem_wr;
      logic       ird;
      logic       ir_wr;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       sesf;
      logic       je;
      logic       alu_src_a;
      logic [1:0] r1_src;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_ctrl;
      logic       instr_done;
      logic       halted;
   } ctrl_t;

   function automatic logic [1:0] r1_src_of(input logic [3:0] op);
      if (op <= OP_OR) return R1S_RB;
      if (op == OP_ADDI || op == OP_ORI || op == OP_BEQ || op == OP_BNE) return R1S_RA;
      return R1S_RP;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Moore output decode for the multi-cycle controller: (state, opcode) -> control bundle.
// hold suppresses every write/strobe while leaving the mux selects untouched.
module multicycle_ctrl_decode
   import risc16_pkg::*;
(
   input  state_e     state,
   input  logic [3:0] opcode,
   input  logic       hold,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         StFetch: begin
            ctrl.ird       = 1'b1;
            ctrl.ir_wr     = 1'b1;
            ctrl.alu_src_b = ASB_TWO;
            ctrl.alu_ctrl  = ALU_ADD;
            ctrl.pc_src    = PCS_ALU;
            ctrl.pc_write  = 1'b1;
         end
         StDecode: begin
            ctrl.alu_src_b = ASB_SHL;
            ctrl.sesf      = 1'b1;
            ctrl.r1_src    = r1_src_of(opcode);
         end
         StExecR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ASB_REG;
            ctrl.alu_ctrl  = opcode[2:0];
            ctrl.r1_src    = r1_src_of(opcode);
         end
         StExecI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ASB_IMM;
            ctrl.sesf      = (opcode == OP_ADDI);
            ctrl.alu_ctrl  = (opcode == OP_ADDI) ? ALU_ADD : ALU_OR;
            ctrl.r1_src    = r1_src_of(opcode);
         end
         StWbAlu: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.r1_src     = r1_src_of(opcode);
         end
         StAddr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ASB_IMM;
            ctrl.sesf      = 1'b1;
            ctrl.alu_ctrl  = ALU_ADD;
            ctrl.r1_src    = r1_src_of(opcode);
         end
         StMemRd: begin
            ctrl.mem_rd = 1'b1;
            ctrl.r1_src = r1_src_of(opcode);
         end
         StWbMem: begin
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.r1_src     = r1_src_of(opcode);
         end
         StMemWr: begin
            ctrl.mem_wr     = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.r1_src     = r1_src_of(opcode);
         end
         StBr: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = ASB_REG;
            ctrl.alu_ctrl      = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = PCS_ALUOUT;
            ctrl.bneq          = (opcode == OP_BNE);
            ctrl.instr_done    = 1'b1;
            ctrl.r1_src        = r1_src_of(opcode);
         end
         StJmp: begin
            ctrl.alu_src_b  = ASB_IMM;
            ctrl.je         = 1'b1;
            ctrl.alu_ctrl   = ALU_ADD;
            ctrl.pc_src     = PCS_ALU;
            ctrl.pc_write   = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.r1_src     = r1_src_of(opcode);
         end
         StJmpR: begin
            ctrl.reg_dst    = 1'b1;
            ctrl.pc_src     = PCS_REG;
            ctrl.pc_write   = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.r1_src     = r1_src_of(opcode);
         end
         StHalt:  ctrl.halted = 1'b1;
         default: ctrl = '0;
      endcase

      if (hold) begin
         ctrl.pc_write      = 1'b0;
         ctrl.pc_write_cond = 1'b0;
         ctrl.mem_rd        = 1'b0;
         ctrl.mem_wr        = 1'b0;
         ctrl.ird           = 1'b0;
         ctrl.ir_wr         = 1'b0;
         ctrl.reg_write     = 1'b0;
         ctrl.instr_done    = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the 16-bit multi-cycle datapath one instruction at a time.
// Holds the state register and next-state logic; outputs come from multicycle_ctrl_decode.
module multicycle_ctrl
   import risc16_pkg::*;
#(
   parameter logic [3:0]  HALT_OP = OP_HALT,
   parameter int unsigned ST_W    = STATE_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      opcode,
   input  logic            hold,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic            BNEq,
   output logic            MemRd,
   output logic            MemWr,
   output logic            IRd,
   output logic            IRWr,
   output logic            RegWrite,
   output logic            RegDst,
   output logic            MemToReg,
   output logic            SESF,
   output logic            JE,
   output logic            ALUSrcA,
   output logic [1:0]      R1Src,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      PCSrc,
   output logic [2:0]      ALUCtrl,
   output logic            instr_done,
   output logic            halted,
   output logic [ST_W-1:0] dbg_state
);

   state_e state_q, state_d, state_nxt;
   logic   state_known;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_nxt   = StIdle;
      state_known = 1'b1;
      case (state_q)
         StIdle:   state_nxt = StFetch;
         StFetch:  state_nxt = StDecode;
         StDecode: begin
            if (opcode == HALT_OP) begin
               state_nxt = StHalt;
            end else begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_SLL, OP_SRL,
                  OP_SAR, OP_NAND, OP_OR:  state_nxt = StExecR;
                  OP_ADDI, OP_ORI:         state_nxt = StExecI;
                  OP_LW, OP_SW:            state_nxt = StAddr;
                  OP_BEQ, OP_BNE:          state_nxt = StBr;
                  OP_J:                    state_nxt = StJmp;
                  OP_JR:                   state_nxt = StJmpR;
                  default:                 state_nxt = StFetch;
               endcase
            end
         end
         StExecR, StExecI: state_nxt = StWbAlu;
         StAddr:   state_nxt = (opcode == OP_LW) ? StMemRd : StMemWr;
         StMemRd:  state_nxt = StWbMem;
         StWbAlu, StWbMem, StMemWr,
         StBr, StJmp, StJmpR: state_nxt = StFetch;
         StHalt:   state_nxt = StHalt;
         default: begin
            state_nxt   = StIdle;
            state_known = 1'b0;
         end
      endcase
      // An illegal code recovers to IDLE even under hold
      state_d = (hold && state_known) ? state_q : state_nxt;
   end

   multicycle_ctrl_decode u_decode (
      .state  (state_q),
      .opcode (opcode),
      .hold   (hold),
      .ctrl   (ctrl)
   );

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign BNEq        = ctrl.bneq;
   assign MemRd       = ctrl.mem_rd;
   assign MemWr       = ctrl.mem_wr;
   assign IRd         = ctrl.ird;
   assign IRWr        = ctrl.ir_wr;
   assign RegWrite    = ctrl.reg_write;
   assign RegDst      = ctrl.reg_dst;
   assign MemToReg    = ctrl.mem_to_reg;
   assign SESF        = ctrl.sesf;
   assign JE          = ctrl.je;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign R1Src       = ctrl.r1_src;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign PCSrc       = ctrl.pc_src;
   assign ALUCtrl     = ctrl.alu_ctrl;
   assign instr_done  = ctrl.instr_done;
   assign halted      = ctrl.halted;
   assign dbg_state   = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class state by state and
// compares the state code and the full control word against hand-written values.
module tb_multicycle_ctrl;
   import risc16_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] opcode;
   logic       hold;
   logic       PCWrite, PCWriteCond, BNEq, MemRd, MemWr, IRd, IRWr, RegWrite;
   logic       RegDst, MemToReg, SESF, JE, ALUSrcA;
   logic [1:0] R1Src, ALUSrcB, PCSrc;
   logic [2:0] ALUCtrl;
   logic       instr_done, halted;
   logic [3:0] dbg_state;

   int errors = 0;
   int checks = 0;

   multicycle_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .hold        (hold),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .BNEq        (BNEq),
      .MemRd       (MemRd),
      .MemWr       (MemWr),
      .IRd         (IRd),
      .IRWr        (IRWr),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .MemToReg    (MemToReg),
      .SESF        (SESF),
      .JE          (JE),
      .ALUSrcA     (ALUSrcA),
      .R1Src       (R1Src),
      .ALUSrcB     (ALUSrcB),
      .PCSrc       (PCSrc),
      .ALUCtrl     (ALUCtrl),
      .instr_done  (instr_done),
      .halted      (halted),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   // strobes: {PCWrite,PCWriteCond,BNEq,MemRd,MemWr,IRd,IRWr,RegWrite}
   // sel:     {RegDst,MemToReg,SESF,JE,ALUSrcA}
   function automatic logic [23:0] cw(input logic [7:0] strobes, input logic [4:0] sel,
                                      input logic [1:0] r1s, input logic [1:0] asb,
                                      input logic [1:0] pcs, input logic [2:0] alu,
                                      input logic done, input logic hlt);
      return {strobes, sel, r1s, asb, pcs, alu, done, hlt};
   endfunction

   logic [23:0] obs;
   assign obs = {PCWrite, PCWriteCond, BNEq, MemRd, MemWr, IRd, IRWr, RegWrite,
                 RegDst, MemToReg, SESF, JE, ALUSrcA, R1Src, ALUSrcB, PCSrc, ALUCtrl,
                 instr_done, halted};

   task automatic expect_st(input string tag, input logic [3:0] st, input logic [23:0] w);
      checks++;
      assert (dbg_state === st) else begin
         errors++;
         $error("FAIL %s state: got %0d want %0d", tag, dbg_state, st);
      end
      checks++;
      assert (obs === w) else begin
         errors++;
         $error("FAIL %s ctrl: got %06h want %06h", tag, obs, w);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [23:0] W_ZERO  = 24'h0;
   localparam logic [23:0] W_FETCH = {8'b1000_0110, 5'b00000, 2'b00, 2'b01, 2'b10, 3'b000,
                                      1'b0, 1'b0};

   initial begin
      rst_n  = 1'b0;
      opcode = 4'h1;
      hold   = 1'b0;
      step();
      expect_st("reset", 4'd0, W_ZERO);
      step();
      rst_n = 1'b1;
      #1;
      expect_st("idle_after_release", 4'd0, W_ZERO);

      // SUB
      step(); expect_st("sub_fetch", 4'd1, W_FETCH);
      step(); expect_st("sub_decode", 4'd2, cw(8'h00, 5'b00100, 2'b01, 2'b11, 2'b00, 3'b000, 0, 0));
      step(); expect_st("sub_exec", 4'd3, cw(8'h00, 5'b00001, 2'b01, 2'b00, 2'b00, 3'b001, 0, 0));
      step(); expect_st("sub_wb", 4'd5, cw(8'h01, 5'b00000, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));
      opcode = 4'h9;

      // LW
      step(); expect_st("lw_fetch", 4'd1, W_FETCH);
      step(); expect_st("lw_decode", 4'd2, cw(8'h00, 5'b00100, 2'b00, 2'b11, 2'b00, 3'b000, 0, 0));
      step(); expect_st("lw_addr", 4'd6, cw(8'h00, 5'b00101, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
      step(); expect_st("lw_memrd", 4'd7, cw(8'h10, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
      step(); expect_st("lw_wb", 4'd8, cw(8'h01, 5'b11000, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
      opcode = 4'hC;

      // BNE
      step(); expect_st("bne_fetch", 4'd1, W_FETCH);
      step(); expect_st("bne_decode", 4'd2, cw(8'h00, 5'b00100, 2'b10, 2'b11, 2'b00, 3'b000, 0, 0));
      step(); expect_st("bne_br", 4'd10, cw(8'h60, 5'b00001, 2'b10, 2'b00, 2'b00, 3'b001, 1, 0));
      opcode = 4'hB;

      // BEQ
      step(); expect_st("beq_fetch", 4'd1, W_FETCH);
      step(); expect_st("beq_decode", 4'd2, cw(8'h00, 5'b00100, 2'b10, 2'b11, 2'b00, 3'b000, 0, 0));
      step(); expect_st("beq_br", 4'd10, cw(8'h40, 5'b00001, 2'b10, 2'b00, 2'b00, 3'b001, 1, 0));
      opcode = 4'h8;

      // ORI
      step(); expect_st("ori_fetch", 4'd1, W_FETCH);
      step(); expect_st("ori_decode", 4'd2, cw(8'h00, 5'b00100, 2'b10, 2'b11, 2'b00, 3'b000, 0, 0));
      step(); expect_st("ori_exec", 4'd4, cw(8'h00, 5'b00001, 2'b10, 2'b10, 2'b00, 3'b110, 0, 0));
      step(); expect_st("ori_wb", 4'd5, cw(8'h01, 5'b00000, 2'b10, 2'b00, 2'b00, 3'b000, 1, 0));
      opcode = 4'hA;

      // SW with hold during MEM_WR
      step(); expect_st("sw_fetch", 4'd1, W_FETCH);
      step(); expect_st("sw_decode", 4'd2, cw(8'h00, 5'b00100, 2'b00, 2'b11, 2'b00, 3'b000, 0, 0));
      step(); expect_st("sw_addr", 4'd6, cw(8'h00, 5'b00101, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
      step();
      hold = 1'b1;
      #1;
      expect_st("sw_hold0", 4'd9, cw(8'h00, 5'b10000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
      step(); expect_st("sw_hold1", 4'd9, cw(8'h00, 5'b10000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
      step(); expect_st("sw_hold2", 4'd9, cw(8'h00, 5'b10000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
      hold = 1'b0;
      #1;
      expect_st("sw_memwr", 4'd9, cw(8'h08, 5'b10000, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
      opcode = 4'hD;

      // J
      step(); expect_st("j_fetch", 4'd1, W_FETCH);
      step(); expect_st("j_decode", 4'd2, cw(8'h00, 5'b00100, 2'b00, 2'b11, 2'b00, 3'b000, 0, 0));
      step(); expect_st("j_jmp", 4'd11, cw(8'h80, 5'b00010, 2'b00, 2'b10, 2'b10, 3'b000, 1, 0));
      opcode = 4'hE;

      // JR
      step(); expect_st("jr_fetch", 4'd1, W_FETCH);
      step(); expect_st("jr_decode", 4'd2, cw(8'h00, 5'b00100, 2'b00, 2'b11, 2'b00, 3'b000, 0, 0));
      step(); expect_st("jr_jmpr", 4'd12, cw(8'h80, 5'b10000, 2'b00, 2'b00, 2'b01, 3'b000, 1, 0));
      opcode = 4'hF;

      // HALT, then escape via reset
      step(); expect_st("halt_fetch", 4'd1, W_FETCH);
      step(); expect_st("halt_decode", 4'd2, cw(8'h00, 5'b00100, 2'b00, 2'b11, 2'b00, 3'b000, 0, 0));
      for (int i = 0; i < 20; i++) begin
         step();
         expect_st($sformatf("halt_%0d", i), 4'd13, 24'h000001);
      end
      #2;
      rst_n = 1'b0;
      #1;
      expect_st("halt_reset", 4'd0, W_ZERO);
      step();
      rst_n = 1'b1;
      #1;
      expect_st("idle_again", 4'd0, W_ZERO);
      step(); expect_st("fetch_again", 4'd1, W_FETCH);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
